mlp_seq_engine: RTL

Parametrised, time-multiplexed successor to the fixed 4-4-2 ReLU network. It computes a two-layer perceptron, y = W2 · ReLU(W1 · x), with runtime-loadable weights and one shared signed MAC stepped by an FSM. It has valid/ready handshakes on input and output and sits between the feature front-end and the classifier back-end.

---
 rtl/mlp_seq_engine.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mlp_seq_engine.sv
// Time-multiplexed two-layer perceptron y = W2 * ReLU(W1 * x) built around one shared signed MAC.
// Weights live in a runtime-writable register file that can only be updated while the engine is idle.
module mlp_seq_engine #(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int XW    = 7,
  parameter int WW    = 5,
  localparam int HW   = XW + WW + $clog2(N_IN),
  localparam int OW   = HW + WW + $clog2(N_HID),
  localparam int NW   = N_IN * N_HID + N_HID * N_OUT,
  localparam int AW   = $clog2(NW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*XW-1:0]    x_flat,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic [WW-1:0]         w_data,
  output logic                  wr_drop,
  output logic [N_OUT*OW-1:0]   y_flat,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int IIW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JIW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int OIW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IIW-1:0] LAST_I = IIW'(N_IN - 1);
  localparam logic [JIW-1:0] LAST_J = JIW'(N_HID - 1);
  localparam logic [OIW-1:0] LAST_O = OIW'(N_OUT - 1);
  localparam logic [AW:0]    NW_C   = (AW + 1)'(NW);

  typedef enum logic [1:0] {S_IDLE, S_L1, S_L2, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [IIW-1:0]        i_q, i_d;
  logic [JIW-1:0]        j_q, j_d;
  logic [OIW-1:0]        o_q, o_d;
  logic signed [OW-1:0]  acc_q, acc_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  wr_drop_q, wr_drop_d;

  logic signed [XW-1:0]  x_q [N_IN];
  logic signed [WW-1:0]  w_q [NW];
  logic signed [HW-1:0]  h_q [N_HID];
  logic signed [OW-1:0]  y_q [N_OUT];

  logic                  x_ld_s, h_we_s, y_we_s, w_commit_s;
  logic [AW-1:0]         raddr_s;
  logic signed [HW-1:0]  mul_a_s;
  logic signed [WW-1:0]  mul_b_s;
  logic signed [HW+WW-1:0] prod_s;
  logic signed [OW-1:0]  sum_s;
  logic signed [HW-1:0]  relu_s;

  // Shared MAC: operand selection depends on which layer is being evaluated.
  always_comb begin
    if (state_q == S_L2) begin
      raddr_s = AW'(N_IN * N_HID + int'(j_q) * N_OUT + int'(o_q));
      mul_a_s = h_q[j_q];
    end else begin
      raddr_s = AW'(int'(i_q) * N_HID + int'(j_q));
      mul_a_s = HW'(x_q[i_q]);
    end
    mul_b_s = w_q[raddr_s];
    prod_s  = mul_a_s * mul_b_s;
    sum_s   = acc_q + OW'(prod_s);
    relu_s  = sum_s[OW-1] ? '0 : sum_s[HW-1:0];
  end

  assign w_commit_s = w_we && (state_q == S_IDLE) && ({1'b0, w_addr} < NW_C);

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    o_d         = o_q;
    acc_d       = acc_q;
    in_ready_d  = 1'b0;
    out_valid_d = out_valid_q;
    wr_drop_d   = w_we && !w_commit_s;
    x_ld_s      = 1'b0;
    h_we_s      = 1'b0;
    y_we_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_ld_s     = 1'b1;
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          o_d        = '0;
          state_d    = S_L1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_L1: begin
        acc_d = sum_s;
        if (i_q == LAST_I) begin
          h_we_s = 1'b1;
          acc_d  = '0;
          i_d    = '0;
          if (j_q == LAST_J) begin
            j_d     = '0;
            state_d = S_L2;
          end else begin
            j_d = j_q + JIW'(1);
          end
        end else begin
          i_d = i_q + IIW'(1);
        end
      end
      S_L2: begin
        acc_d = sum_s;
        if (j_q == LAST_J) begin
          y_we_s = 1'b1;
          acc_d  = '0;
          j_d    = '0;
          if (o_q == LAST_O) begin
            o_d         = '0;
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            o_d = o_q + OIW'(1);
          end
        end else begin
          j_d = j_q + JIW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      o_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      o_q         <= o_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  // Storage arrays: weights, captured inputs, hidden activations and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NW; n++)    w_q[n] <= '0;
      for (int n = 0; n < N_IN; n++)  x_q[n] <= '0;
      for (int n = 0; n < N_HID; n++) h_q[n] <= '0;
      for (int n = 0; n < N_OUT; n++) y_q[n] <= '0;
    end else begin
      if (w_commit_s) w_q[w_addr] <= w_data;
      if (x_ld_s) begin
        for (int n = 0; n < N_IN; n++) x_q[n] <= x_flat[n*XW +: XW];
      end
      if (h_we_s) h_q[j_q] <= relu_s;
      if (y_we_s) y_q[o_q] <= sum_s;
    end
  end

  always_comb begin
    y_flat = '0;
    for (int n = 0; n < N_OUT; n++) y_flat[n*OW +: OW] = y_q[n];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign wr_drop   = wr_drop_q;

endmodule
